// File: rtl/pipe_defs.sv
// Shared definitions for the MAC pipeline issue stage: one-hot
// instruction bit positions, issuer state encoding, word checker.
package pipe_defs;

   localparam int INST_W   = 8;
   localparam int NOP      = 0;
   localparam int LD_DATA  = 1;
   localparam int LD_COEFF = 2;
   localparam int MULT     = 3;
   localparam int ADD      = 4;
   localparam int WRITE    = 5;

   localparam logic [INST_W-1:0] NOP_WORD = INST_W'(1) << NOP;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } iss_state_t;

   // A word is malformed if empty, if it combines more than one of
   // the memory ops, or if it pairs an op with its own hazard partner.
   function automatic logic is_malformed(input logic [INST_W-1:0] w);
      logic [1:0] n_mem;
      n_mem = 2'(w[LD_DATA]) + 2'(w[LD_COEFF]) + 2'(w[WRITE]);
      return (w == '0)
          || (n_mem > 2'd1)
          || (w[MULT] && (w[LD_DATA] || w[LD_COEFF]))
          || (w[ADD] && w[WRITE]);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Load->MULT and WRITE->ADD spacing tracker for the issuer.
// Ports: clk, reset (async high), issued (word sent this cycle),
// cand (word waiting at pc), stall (cand must wait).
module hazard_scoreboard
   import pipe_defs::*;
#(
   parameter int LOAD_LAT  = 2,
   parameter int WRITE_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INST_W-1:0] issued,
   input  logic [INST_W-1:0] cand,
   output logic              stall
);

   localparam int LW = $clog2(LOAD_LAT + 1);
   localparam int WW = $clog2(WRITE_LAT + 1);

   logic [LW-1:0] ld_cnt_q, ld_cnt_d;
   logic [WW-1:0] wr_cnt_q, wr_cnt_d;
   logic          unused_bits;

   assign unused_bits = ^{issued, cand};

   always_comb begin
      ld_cnt_d = ld_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (issued[LD_DATA] || issued[LD_COEFF]) begin
         ld_cnt_d = LW'(LOAD_LAT - 1);
      end else if (ld_cnt_q != '0) begin
         ld_cnt_d = ld_cnt_q - LW'(1);
      end
      if (issued[WRITE]) begin
         wr_cnt_d = WW'(WRITE_LAT - 1);
      end else if (wr_cnt_q != '0) begin
         wr_cnt_d = wr_cnt_q - WW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign stall = (cand[MULT] && (ld_cnt_q != '0))
               || (cand[ADD]  && (wr_cnt_q != '0));

endmodule

// File: rtl/inst_issuer.sv
// Program sequencer feeding one-hot words to the MAC pipeline, with
// hazard bubbles and a NOP drain tail.
// Ports: clk, reset (async high); prog_we/prog_addr/prog_data write
// the program; prog_len/start launch; inst, busy, done, illegal, pc.
// Option STALL_COUNT_EN adds stall_cnt[15:0] (stall cycles this run).
module inst_issuer
   import pipe_defs::*;
#(
   parameter  int PROG_DEPTH   = 16,
   parameter  int LOAD_LAT     = 2,
   parameter  int WRITE_LAT    = 2,
   parameter  int DRAIN_CYCLES = 4,
   localparam int AW           = $clog2(PROG_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [INST_W-1:0] prog_data,
   input  logic [AW:0]       prog_len,
   input  logic              start,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic [AW-1:0]     pc
`ifdef STALL_COUNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   logic [INST_W-1:0] mem [PROG_DEPTH];

   iss_state_t        state_q, state_d;
   logic [AW:0]       len_q, len_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              illegal_q, illegal_d;
   logic [DW-1:0]     drain_q, drain_d;

   logic [INST_W-1:0] word;
   logic              bad;
   logic              hz_stall;
   logic              stall_ev;
   logic              last_word;
   logic              drain_end;

   // Writes land at the edge, so a same-cycle start reads the new word.
   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         mem[prog_addr] <= prog_data;
      end
   end

   assign word      = mem[pc_q];
   assign bad       = is_malformed(word);
   assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
   assign drain_end = (drain_q == DW'(DRAIN_CYCLES - 1));

   hazard_scoreboard #(
      .LOAD_LAT  (LOAD_LAT),
      .WRITE_LAT (WRITE_LAT)
   ) u_sb (
      .clk    (clk),
      .reset  (reset),
      .issued (inst_d),
      .cand   (word),
      .stall  (hz_stall)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      pc_d      = pc_q;
      inst_d    = NOP_WORD;
      illegal_d = illegal_q;
      drain_d   = drain_q;
      stall_ev  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d     = prog_len;
               pc_d      = '0;
               illegal_d = 1'b0;
               drain_d   = '0;
               state_d   = (prog_len == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            // A malformed word is consumed as a NOP, never stalled.
            if (bad) begin
               illegal_d = 1'b1;
               pc_d      = pc_q + AW'(1);
            end else if (hz_stall) begin
               stall_ev  = 1'b1;
            end else begin
               inst_d    = word;
               pc_d      = pc_q + AW'(1);
            end
            if (!stall_ev && last_word) begin
               state_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            if (drain_end) begin
               state_d = IDLE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         pc_q      <= '0;
         inst_q    <= NOP_WORD;
         illegal_q <= 1'b0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         illegal_q <= illegal_d;
         drain_q   <= drain_d;
      end
   end

   assign inst    = inst_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DRAIN) && drain_end;
   assign illegal = illegal_q;
   assign pc      = pc_q;

`ifdef STALL_COUNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IDLE) && start) begin
         stall_cnt_d = '0;
      end else if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_issuer.sv
// Self-checking bench for inst_issuer: fixed program table, a few
// hand-timed corner sequences, and random programs against a model.
module tb_inst_issuer;

   localparam int DEPTH  = 16;
   localparam int LD_LAT = 2;
   localparam int WR_LAT = 2;
   localparam int DRAIN  = 4;
   localparam int MAXC   = 64;
   localparam logic [7:0] NOPW = 8'h01;

   logic       clk = 1'b0;
   logic       reset;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [4:0] prog_len;
   logic       start;
   logic [7:0] inst;
   logic       busy;
   logic       done;
   logic       illegal;
   logic [3:0] pc;
`ifdef STALL_COUNT_EN
   logic [15:0] stall_cnt;
`endif

   inst_issuer #(
      .PROG_DEPTH   (DEPTH),
      .LOAD_LAT     (LD_LAT),
      .WRITE_LAT    (WR_LAT),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_len  (prog_len),
      .start     (start),
      .inst      (inst),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal),
      .pc        (pc)
`ifdef STALL_COUNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [0:8][7:0]  prog;
      int               len;
      logic [0:10][7:0] stream;
      int               nstream;
      int               done_c;
      int               ill_c;
      int               nstall;
   } vec_t;

   vec_t vecs[5];

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rprog [16];
   logic [7:0] obs_inst [MAXC];
   logic       obs_busy [MAXC];
   logic       obs_done [MAXC];
   logic       obs_ill  [MAXC];
   logic [3:0] obs_pc   [MAXC];
   logic [7:0] exp_inst [MAXC];
   logic       exp_busy [MAXC];
   logic       exp_done [MAXC];
   logic       exp_ill  [MAXC];
   logic [3:0] exp_pc   [MAXC];
   logic [15:0] obs_stall;
   int          exp_stall;

   logic [7:0] pool [13] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h18,
                             8'h01, 8'h12, 8'h0A, 8'h06, 8'h30, 8'h00,
                             8'h18};

   function automatic void chk(string nm, int c, logic [15:0] act,
                               logic [15:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s cyc %0d got %0h want %0h", nm, c, act, want);
      end
   endfunction

   function automatic bit bad_word(logic [7:0] w);
      int n;
      n = int'(w[1]) + int'(w[2]) + int'(w[5]);
      return (w == 8'h00) || (n > 1) || (w[3] && (w[1] || w[2]))
          || (w[4] && w[5]);
   endfunction

   task automatic write_prog(input int n);
      for (int i = 0; i < n; i++) begin
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         prog_data = rprog[i];
         @(posedge clk);
         #1;
      end
      prog_we = 1'b0;
   endtask

   task automatic run_capture(input int len, input int ncyc);
      prog_len = 5'(len);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      prog_we = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         obs_inst[c] = inst;
         obs_busy[c] = busy;
         obs_done[c] = done;
         obs_ill[c]  = illegal;
         obs_pc[c]   = pc;
      end
`ifdef STALL_COUNT_EN
      obs_stall = stall_cnt;
`else
      obs_stall = 16'(exp_stall);
`endif
   endtask

   task automatic check_trace(input string nm, input int ncyc,
                              input bit do_pc);
      for (int c = 0; c < ncyc; c++) begin
         chk({nm, "_inst"}, c, 16'(obs_inst[c]), 16'(exp_inst[c]));
         chk({nm, "_busy"}, c, 16'(obs_busy[c]), 16'(exp_busy[c]));
         chk({nm, "_done"}, c, 16'(obs_done[c]), 16'(exp_done[c]));
         chk({nm, "_ill"},  c, 16'(obs_ill[c]),  16'(exp_ill[c]));
         if (do_pc) begin
            chk({nm, "_pc"}, c, 16'(obs_pc[c]), 16'(exp_pc[c]));
         end
      end
`ifdef STALL_COUNT_EN
      chk({nm, "_stalls"}, ncyc, obs_stall, 16'(exp_stall));
`endif
   endtask

   task automatic apply_vec(input int k);
      vec_t v;
      v = vecs[k];
      for (int i = 0; i < 9; i++) rprog[i] = v.prog[i];
      write_prog(9);
      for (int c = 0; c < MAXC; c++) begin
         exp_inst[c] = (c >= 1 && c <= v.nstream) ? v.stream[c-1] : NOPW;
         exp_busy[c] = (c <= v.done_c);
         exp_done[c] = (c == v.done_c);
         exp_ill[c]  = (v.ill_c >= 0) && (c >= v.ill_c);
         exp_pc[c]   = 4'h0;
      end
      exp_stall = v.nstall;
      run_capture(v.len, v.done_c + 3);
      check_trace($sformatf("vec%0d", k), v.done_c + 3, 1'b0);
   endtask

   // Slot-by-slot reference: a word with MULT may not go out until
   // LD_LAT slots after the last load, ADD until WR_LAT after WRITE.
   task automatic model(input int len, output int ncyc);
      int t, last_ld, last_wr, ill_at, done_c;
      logic [7:0] w;
      t = 0; last_ld = -100; last_wr = -100; ill_at = MAXC;
      exp_stall = 0;
      for (int c = 0; c < MAXC; c++) begin
         exp_inst[c] = NOPW;
         exp_busy[c] = 1'b0;
         exp_done[c] = 1'b0;
         exp_ill[c]  = 1'b0;
         exp_pc[c]   = 4'(len % DEPTH);
      end
      for (int i = 0; i < len; i++) begin
         w = rprog[i];
         if (bad_word(w)) begin
            exp_pc[t] = 4'(i);
            if (ill_at == MAXC) ill_at = t + 1;
            t++;
         end else begin
            while ((w[3] && (t - last_ld < LD_LAT)) ||
                   (w[4] && (t - last_wr < WR_LAT))) begin
               exp_pc[t] = 4'(i);
               exp_stall++;
               t++;
            end
            exp_pc[t]     = 4'(i);
            exp_inst[t+1] = w;
            if (w[1] || w[2]) last_ld = t;
            if (w[5]) last_wr = t;
            t++;
         end
      end
      done_c = t + DRAIN - 1;
      for (int c = 0; c <= done_c; c++) exp_busy[c] = 1'b1;
      exp_done[done_c] = 1'b1;
      for (int c = ill_at; c < MAXC; c++) exp_ill[c] = 1'b1;
      ncyc = done_c + 3;
   endtask

   initial begin
      int nb, nd, dc, nc, len;

      vecs[0] = '{prog: {8'h02, 8'h04, 8'h18, 8'h18, 8'h18, 8'h18,
                         8'h20, 8'h00, 8'h00},
                  len: 7,
                  stream: {8'h02, 8'h04, 8'h01, 8'h18, 8'h18, 8'h18,
                           8'h18, 8'h20, 8'h01, 8'h01, 8'h01},
                  nstream: 8, done_c: 11, ill_c: -1, nstall: 1};
      vecs[1] = '{prog: {8'h04, 8'h02, 8'h18, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00},
                  len: 3,
                  stream: {8'h04, 8'h02, 8'h01, 8'h18, 8'h01, 8'h01,
                           8'h01, 8'h01, 8'h01, 8'h01, 8'h01},
                  nstream: 4, done_c: 7, ill_c: -1, nstall: 1};
      vecs[2] = '{prog: {8'h04, 8'h01, 8'h02, 8'h18, 8'h18, 8'h20,
                         8'h18, 8'h18, 8'h04},
                  len: 9,
                  stream: {8'h04, 8'h01, 8'h02, 8'h01, 8'h18, 8'h18,
                           8'h20, 8'h01, 8'h18, 8'h18, 8'h04},
                  nstream: 11, done_c: 14, ill_c: -1, nstall: 2};
      vecs[3] = '{prog: {8'h02, 8'h06, 8'h04, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00},
                  len: 3,
                  stream: {8'h02, 8'h01, 8'h04, 8'h01, 8'h01, 8'h01,
                           8'h01, 8'h01, 8'h01, 8'h01, 8'h01},
                  nstream: 3, done_c: 6, ill_c: 2, nstall: 0};
      vecs[4] = '{prog: {8'h02, 8'h04, 8'h18, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00},
                  len: 0,
                  stream: {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                           8'h01, 8'h01, 8'h01, 8'h01, 8'h01},
                  nstream: 0, done_c: 3, ill_c: -1, nstall: 0};

      reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      prog_len = '0; start = 1'b0; exp_stall = 0;
      @(negedge clk);
      chk("reset_inst", 0, 16'(inst), 16'(NOPW));
      chk("reset_busy", 0, 16'(busy), 16'h0);
      chk("reset_done", 0, 16'(done), 16'h0);
      chk("reset_ill",  0, 16'(illegal), 16'h0);
      chk("reset_pc",   0, 16'(pc), 16'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int k = 0; k < 5; k++) apply_vec(k);

      // Asynchronous abort two cycles into a run.
      for (int i = 0; i < 9; i++) rprog[i] = vecs[0].prog[i];
      write_prog(9);
      prog_len = 5'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_pc_pre", 2, 16'(pc), 16'h2);
      #2 reset = 1'b1;
      #1;
      chk("abort_inst", 0, 16'(inst), 16'(NOPW));
      chk("abort_busy", 0, 16'(busy), 16'h0);
      chk("abort_pc",   0, 16'(pc), 16'h0);
      nd = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_nodone", 0, 16'(nd), 16'h0);
      reset = 1'b0;
      apply_vec(0);

      // len=0 run with a second start arriving while busy.
      prog_len = 5'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      nb = 0; nd = 0; dc = -1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin nd++; dc = c; end
         chk("len0_inst", c, 16'(inst), 16'(NOPW));
         start    = (c == 0);
         prog_len = 5'd3;
      end
      start = 1'b0;
      chk("len0_busy_cycles", 0, 16'(nb), 16'd4);
      chk("len0_done_count",  0, 16'(nd), 16'd1);
      chk("len0_done_cycle",  0, 16'(dc), 16'd3);

      // Program writes are dropped while busy.
      rprog[0] = 8'h02; rprog[1] = 8'h04; rprog[2] = 8'h20;
      write_prog(3);
      prog_len = 5'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h10;
      @(negedge clk);
      prog_we = 1'b0;
      repeat (8) @(negedge clk);
      exp_stall = 0;
      run_capture(1, 6);
      chk("busy_write_ignored", 1, 16'(obs_inst[1]), 16'h02);
      chk("len1_done", 4, 16'(obs_done[4]), 16'h1);

      // Write and start in the same idle cycle: start sees new word.
      prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h10;
      run_capture(1, 6);
      chk("write_start_same", 1, 16'(obs_inst[1]), 16'h10);

      // Random programs against the slot model.
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 16; i++) begin
            rprog[i] = pool[$urandom_range(0, 12)];
         end
         write_prog(16);
         len = $urandom_range(0, 16);
         model(len, nc);
         run_capture(len, nc);
         check_trace($sformatf("rnd%0d", r), nc, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
